// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states, lane mask width.
// No logic and no latency of its own.
// No backpressure; holds only types, constants and a helper function.
package mem_access_unit_pkg;

    localparam int LANE_MASK_W = 8;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10
    } state_t;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_HALF: return off[0];
            SIZE_WORD: return off != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-side signal bundle for the load/store sequencer.
// Carries no state; timing is set by the unit behind the slave modport.
// req_valid/req_ready handshake; the RAM side has no backpressure.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              ram_we;
    logic [3:0]        ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Pipeline and RAM side together: issue requests, supply read data.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ram_we, ram_sel, ram_addr, ram_wdata
    );

    // The sequencer itself.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_we, ram_sel, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane math: store mask/shift over a two-word window, load merge/shift/extend.
// Purely combinational, zero latency.
// No backpressure; the caller decides when outputs are used.
module mem_access_unit_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]             size,
    input  logic [1:0]             offset,
    input  logic                   is_unsigned,
    input  logic [31:0]            st_data,
    input  logic [31:0]            ld_lo,
    input  logic [23:0]            ld_hi,
    output logic [LANE_MASK_W-1:0] lane_mask,
    output logic [63:0]            st_lanes,
    output logic                   span,
    output logic [31:0]            ld_data
);
    logic [LANE_MASK_W-1:0] base_mask;
    logic [31:0]            ld_word;

    // Lane mask and shifted store data over word0 (low half) and word1 (high half).
    always_comb begin
        case (size)
            SIZE_BYTE: base_mask = 8'h01;
            SIZE_HALF: base_mask = 8'h03;
            SIZE_WORD: base_mask = 8'h0f;
            default:   base_mask = 8'h00;
        endcase
        lane_mask = base_mask << offset;
        span      = |lane_mask[7:4];
        st_lanes  = {32'h0, st_data} << {offset, 3'b000};
    end

    // Right-justify the addressed bytes out of {hi,lo}; hi byte 3 can never be addressed.
    always_comb begin
        case (offset)
            2'd0:    ld_word = ld_lo;
            2'd1:    ld_word = {ld_hi[7:0],  ld_lo[31:8]};
            2'd2:    ld_word = {ld_hi[15:0], ld_lo[31:16]};
            default: ld_word = {ld_hi[23:0], ld_lo[31:24]};
        endcase
        case (size)
            SIZE_BYTE: ld_data = is_unsigned ? {24'h0, ld_word[7:0]}
                                             : {{24{ld_word[7]}}, ld_word[7:0]};
            SIZE_HALF: ld_data = is_unsigned ? {16'h0, ld_word[15:0]}
                                             : {{16{ld_word[15]}}, ld_word[15:0]};
            SIZE_WORD: ld_data = ld_word;
            default:   ld_data = 32'h0;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer to the byte-lane RAM; splits word-straddling accesses (or rejects them when MISALIGN_TRAP_EN is defined).
// Response 2 cycles after accept, 3 when split, 1 for rejected requests.
// req_ready only in IDLE; the response cycle is IDLE, so back-to-back requests issue without a bubble.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);
    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              ram_we_q, ram_we_d;
    logic [3:0]        ram_sel_q, ram_sel_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic                   idle;
    logic                   reject;
    logic [1:0]             al_size;
    logic [1:0]             al_off;
    logic [DATA_W-1:0]      al_wdata;
    logic [DATA_W-1:0]      ld_lo;
    logic [23:0]            ld_hi;
    logic [LANE_MASK_W-1:0] lane_mask;
    logic [63:0]            st_lanes;
    logic                   span;
    logic [DATA_W-1:0]      ld_data;

    // In IDLE the lane math runs on the incoming request, otherwise on the held one;
    // the current RAM read data is folded in directly so no extra cycle is spent.
    always_comb begin
        idle     = (state_q == ST_IDLE);
        al_size  = idle ? bus.req_size         : size_q;
        al_off   = idle ? bus.req_addr[1:0]    : addr_q[1:0];
        al_wdata = idle ? bus.req_wdata        : wdata_q;
        ld_lo    = (state_q == ST_ACC0) ? bus.ram_rdata : lo_q;
        ld_hi    = (state_q == ST_ACC1) ? bus.ram_rdata[23:0] : 24'h0;
`ifdef MISALIGN_TRAP_EN
        reject   = (bus.req_size == SIZE_ILLEGAL) ||
                   is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
        reject   = (bus.req_size == SIZE_ILLEGAL);
`endif
    end

    mem_access_unit_lane_align u_lane_align (
        .size        (al_size),
        .offset      (al_off),
        .is_unsigned (uns_q),
        .st_data     (al_wdata),
        .ld_lo       (ld_lo),
        .ld_hi       (ld_hi),
        .lane_mask   (lane_mask),
        .st_lanes    (st_lanes),
        .span        (span),
        .ld_data     (ld_data)
    );

    // Next-state and next-output logic for the IDLE -> ACC0 [-> ACC1] -> IDLE sequence.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        ram_we_d     = 1'b0;
        ram_sel_d    = 4'h0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (reject) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_ACC0;
                        req_ready_d = 1'b0;
                        ram_we_d    = bus.req_we;
                        ram_sel_d   = lane_mask[3:0];
                        ram_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        ram_wdata_d = st_lanes[31:0];
                    end
                end
            end
            ST_ACC0: begin
                if (!we_q) begin
                    lo_d = bus.ram_rdata;
                end
                if (span) begin
                    state_d     = ST_ACC1;
                    ram_we_d    = we_q;
                    ram_sel_d   = lane_mask[7:4];
                    ram_addr_d  = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
                    ram_wdata_d = st_lanes[63:32];
                end else begin
                    state_d      = ST_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : ld_data;
                end
            end
            ST_ACC1: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b1;
                resp_rdata_d = we_q ? '0 : ld_data;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State, held request and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_sel_q    <= 4'h0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_we_q     <= ram_we_d;
            ram_sel_q    <= ram_sel_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    // Reset masks the strobes at once so a write in progress when reset arrives never lands.
    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.ram_we     = ram_we_q & ~rst;
    assign bus.ram_sel    = ram_sel_q & {4{~rst}};
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
endmodule
